// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control sequencer.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives datapath enables and mux selects.
// Optional build macro MC_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
//
// state  | meaning
// IDLE   | halted at an instruction boundary, waiting for run
// FETCH  | instruction read; IR and PC load on mem_ready
// DECODE | latch opcode_funct, precompute branch target
// MEMADR | effective address for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | write loaded data to register file
// MEMWR  | data write, wait for mem_ready
// EXEC   | ALU operation for R-type / immediate
// ALUWB  | write ALU result to register file
// BRANCH | conditional PC update (beq/bne)
// JUMP   | unconditional PC update (j/jr)
// TRAP   | undecodable op or memory timeout; left only by rst
module mc_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] opcode_funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_TRAP   = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [15:0] tmo_q, tmo_d;
  logic        illegal_q, illegal_d;
  logic        in_wait;
  logic        tmo_hit;
  logic        end_instr;

  // Next-state, timeout and datapath control decode; Mealy terms use mem_ready/zero.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    retire     = 1'b0;
    end_instr  = 1'b0;
    in_wait    = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // The increment happening this cycle is the one that reaches the limit;
    // a mem_ready in the same cycle still wins.
    tmo_hit    = in_wait && !mem_ready &&
                 (({1'b0, tmo_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = opcode_funct;
        case (opcode_funct)
          7'h23, 7'h2b:                             state_d = S_MEMADR;
          7'h60, 7'h62, 7'h64, 7'h65, 7'h66, 7'h67,
          7'h08, 7'h0c, 7'h0d, 7'h0e:               state_d = S_EXEC;
          7'h04, 7'h05:                             state_d = S_BRANCH;
          7'h02, 7'h48:                             state_d = S_JUMP;
          default:                                  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == 7'h2b) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (tmo_hit) state_d = S_TRAP;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        mem_to_reg = 1'b1;
        end_instr  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready)    end_instr = 1'b1;
        else if (tmo_hit) state_d = S_TRAP;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = op_q[6] ? 2'b00 : 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we     = 1'b1;
        reg_dst   = op_q[6];
        end_instr = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_src    = 2'b01;
        pc_we     = op_q[0] ? ~zero : zero;
        end_instr = 1'b1;
      end
      S_JUMP: begin
        pc_we     = 1'b1;
        pc_src    = op_q[6] ? 2'b11 : 2'b10;
        end_instr = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if (end_instr) begin
      retire  = 1'b1;
      state_d = run ? S_FETCH : S_IDLE;
    end

    // Counter restarts on every entry into a wait state.
    if (state_d != state_q)             tmo_d = 16'd0;
    else if (in_wait && !mem_ready)     tmo_d = tmo_q + 16'd1;
    else                                tmo_d = tmo_q;

    illegal_d = illegal_q | (state_d == S_TRAP);

    // Reset dominates: nothing (including a retire on a late mem_ready) escapes.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      retire     = 1'b0;
    end
  end

  assign illegal = illegal_q & ~rst;
  assign state   = state_q;

  // Sequencer state, latched op, timeout counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 7'd0;
      tmo_q     <= 16'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  // Active-cycle and retired-instruction counts, wrapping modulo 2^32.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire)                                 instr_cnt_d = instr_cnt_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: directed vector table plus timeout sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst, run, zero, mem_ready;
  logic [6:0] opcode_funct;
  logic       mem_req, mem_we, ir_we, pc_we, rf_we, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       retire, illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode_funct(opcode_funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .retire(retire), .illegal(illegal), .state(state)
  );

  typedef struct {
    logic       r;
    logic       n;
    logic [6:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [13:0] o;
  } vec_t;

  vec_t tbl[$];

  // {mem_req, mem_we, ir_we, pc_we, rf_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, retire, illegal}
  function automatic logic [13:0] eo(input logic mr, we, ir, pc, rf, rd, m2r, asa,
                                     input logic [1:0] asb, ps, input logic ret, ill);
    return {mr, we, ir, pc, rf, rd, m2r, asa, asb, ps, ret, ill};
  endfunction

  function automatic logic [13:0] outs();
    return {mem_req, mem_we, ir_we, pc_we, rf_we, reg_dst, mem_to_reg, alu_src_a,
            alu_src_b, pc_src, retire, illegal};
  endfunction

  task automatic add(input logic r, n, input logic [6:0] op, input logic z, rdy,
                     input logic [3:0] st, input logic [13:0] o);
    vec_t v;
    v.r = r; v.n = n; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, n, input logic [6:0] op, input logic z, rdy);
    rst = r; run = n; opcode_funct = op; zero = z; mem_ready = rdy;
  endtask

  logic [13:0] Z, F_WAIT, F_ACK, DEC, EX_R, EX_I, AWB_R, AWB_I, MADR, MRD, MWB,
               MWR_W, MWR_A, BR_T, BR_N, JMP_J, JMP_R, TRP;
  int fetch_cycles;
  bit trapped;

  initial begin
    Z      = '0;
    F_WAIT = eo(1,0,0,0,0,0,0,0,2'b01,2'b00,0,0);
    F_ACK  = eo(1,0,1,1,0,0,0,0,2'b01,2'b00,0,0);
    DEC    = eo(0,0,0,0,0,0,0,0,2'b11,2'b00,0,0);
    EX_R   = eo(0,0,0,0,0,0,0,1,2'b00,2'b00,0,0);
    EX_I   = eo(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
    AWB_R  = eo(0,0,0,0,1,1,0,0,2'b00,2'b00,1,0);
    AWB_I  = eo(0,0,0,0,1,0,0,0,2'b00,2'b00,1,0);
    MADR   = eo(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0);
    MRD    = eo(1,0,0,0,0,0,0,0,2'b00,2'b00,0,0);
    MWB    = eo(0,0,0,0,1,0,1,0,2'b00,2'b00,1,0);
    MWR_W  = eo(1,1,0,0,0,0,0,0,2'b00,2'b00,0,0);
    MWR_A  = eo(1,1,0,0,0,0,0,0,2'b00,2'b00,1,0);
    BR_T   = eo(0,0,0,1,0,0,0,1,2'b00,2'b01,1,0);
    BR_N   = eo(0,0,0,0,0,0,0,1,2'b00,2'b01,1,0);
    JMP_J  = eo(0,0,0,1,0,0,0,0,2'b00,2'b10,1,0);
    JMP_R  = eo(0,0,0,1,0,0,0,0,2'b00,2'b11,1,0);
    TRP    = eo(0,0,0,0,0,0,0,0,2'b00,2'b00,0,1);

    //  r  n  op     z  rdy st  outputs
    add(1, 0, 7'h00, 0, 0, 0,  Z);       // reset state
    add(0, 1, 7'h60, 0, 1, 0,  Z);       // IDLE sees run
    add(0, 1, 7'h60, 0, 1, 1,  F_ACK);   // add
    add(0, 1, 7'h60, 0, 1, 2,  DEC);
    add(0, 1, 7'h60, 0, 1, 7,  EX_R);
    add(0, 1, 7'h60, 0, 1, 8,  AWB_R);
    add(0, 1, 7'h23, 0, 0, 1,  F_WAIT);  // lw, fetch waits 3 cycles
    add(0, 1, 7'h23, 0, 0, 1,  F_WAIT);
    add(0, 1, 7'h23, 0, 0, 1,  F_WAIT);
    add(0, 1, 7'h23, 0, 1, 1,  F_ACK);   // ack on the 4th cycle beats timeout=4
    add(0, 1, 7'h23, 0, 0, 2,  DEC);
    add(0, 1, 7'h23, 0, 0, 3,  MADR);
    add(0, 1, 7'h00, 0, 0, 4,  MRD);
    add(0, 1, 7'h00, 0, 0, 4,  MRD);
    add(0, 1, 7'h00, 0, 0, 4,  MRD);
    add(0, 1, 7'h00, 0, 1, 4,  MRD);
    add(0, 1, 7'h00, 0, 0, 5,  MWB);
    add(0, 1, 7'h04, 0, 1, 1,  F_ACK);   // beq taken
    add(0, 1, 7'h04, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 1, 0, 9,  BR_T);
    add(0, 1, 7'h04, 0, 1, 1,  F_ACK);   // beq not taken
    add(0, 1, 7'h04, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 9,  BR_N);
    add(0, 1, 7'h05, 0, 1, 1,  F_ACK);   // bne taken
    add(0, 1, 7'h05, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 9,  BR_T);
    add(0, 1, 7'h08, 0, 1, 1,  F_ACK);   // addi, run dropped in EXEC
    add(0, 1, 7'h08, 0, 0, 2,  DEC);
    add(0, 0, 7'h00, 0, 0, 7,  EX_I);
    add(0, 0, 7'h00, 0, 0, 8,  AWB_I);
    add(0, 1, 7'h2b, 0, 1, 0,  Z);       // idle, resume
    add(0, 1, 7'h2b, 0, 1, 1,  F_ACK);   // sw
    add(0, 1, 7'h2b, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 3,  MADR);
    add(0, 1, 7'h00, 0, 0, 6,  MWR_W);
    add(0, 1, 7'h00, 0, 1, 6,  MWR_A);
    add(0, 1, 7'h48, 0, 1, 1,  F_ACK);   // jr
    add(0, 1, 7'h48, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 10, JMP_R);
    add(0, 1, 7'h02, 0, 1, 1,  F_ACK);   // j
    add(0, 1, 7'h02, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 10, JMP_J);
    add(0, 1, 7'h2b, 0, 1, 1,  F_ACK);   // sw, reset mid-access
    add(0, 1, 7'h2b, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 3,  MADR);
    add(1, 1, 7'h00, 0, 1, 6,  Z);       // rst wins over mem_ready, no retire
    add(0, 0, 7'h00, 0, 1, 0,  Z);       // mem_ready ignored in IDLE
    add(0, 1, 7'h3f, 0, 1, 0,  Z);       // illegal op
    add(0, 1, 7'h3f, 0, 1, 1,  F_ACK);
    add(0, 1, 7'h3f, 0, 0, 2,  DEC);
    add(0, 1, 7'h00, 0, 0, 11, TRP);
    add(0, 1, 7'h00, 0, 1, 11, TRP);     // TRAP holds
    add(1, 0, 7'h00, 0, 0, 11, Z);
    add(0, 0, 7'h00, 0, 0, 0,  Z);       // back to IDLE, illegal cleared

    drive(1, 0, 7'h00, 0, 0);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].n, tbl[i].op, tbl[i].z, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d state,outs", i), {14'd0, state, outs()}, {14'd0, tbl[i].st, tbl[i].o});
      @(negedge clk);
    end

    // Timeout: no ack in FETCH traps after exactly 4 FETCH cycles.
    drive(0, 1, 7'h00, 0, 0);
    #1; chk("to_idle", {28'd0, state}, 32'd0);
    @(negedge clk);
    fetch_cycles = 0;
    trapped = 0;
    for (int c = 0; c < 10 && !trapped; c++) begin
      #1;
      if (state == 4'd11) trapped = 1;
      else if (state == 4'd1) fetch_cycles++;
      @(negedge clk);
    end
    chk("to_trapped", {31'd0, trapped}, 32'd1);
    chk("to_fetch_cycles", fetch_cycles, 4);
    #1; chk("to_illegal", {31'd0, illegal}, 32'd1);

    // Repeat with ack on the 4th FETCH cycle: no trap.
    drive(1, 0, 7'h00, 0, 0);
    @(negedge clk);
    drive(0, 1, 7'h60, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      #1; chk($sformatf("ack4_fetch%0d", c), {28'd0, state}, 32'd1);
      @(negedge clk);
    end
    #1;
    chk("ack4_decode", {28'd0, state}, 32'd2);
    chk("ack4_no_illegal", {31'd0, illegal}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle sequencer for the 32-bit MIPS datapath. It takes the 7-bit opcode_funct code produced by the instruction decoder and drives the datapath enables and mux selects. It steps each instruction through fetch, decode, execute, memory and writeback, using a request/ready handshake with the unified instruction/data memory. It also sits between the register file, the ALU operand muxes and the PC update logic.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may stay unacknowledged before trapping (1..65535)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
run  in  1  1 = start/continue fetching; 0 = halt at next instruction boundary
opcode_funct  in  7  decoder code: bit6 = R-type, [5:0] = funct (R) or opcode (I/J)
zero  in  1  ALU zero flag, sampled in BRANCH
mem_ready  in  1  memory acknowledge for the current mem_req
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  1 = store access (valid with mem_req)
ir_we  out  1  instruction register load
pc_we  out  1  PC load
rf_we  out  1  register file write
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = writeback from memory data
alu_src_a  out  1  0 = PC, 1 = reg1
alu_src_b  out  2  00 reg2, 01 const 4, 10 signImm, 11 signImm<<2
pc_src  out  2  00 ALU result, 01 branch target reg, 10 jump target, 11 reg1 (jr)
retire  out  1  one-cycle pulse on the final cycle of each completed instruction
illegal  out  1  sticky: undecodable opcode_funct or memory timeout
state  out  4  current state encoding (debug)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, TRAP=11.
- Reset: state=IDLE. All outputs 0; internal latched op, timeout counter and illegal cleared. rst wins over every other event, including a pending mem_ready mid-access.
- IDLE: outputs 0. Goes to FETCH when run=1.
- FETCH: mem_req=1, alu_src_a=0, alu_src_b=01, pc_src=00.
  - On mem_ready=1: ir_we=1 and pc_we=1 in the same cycle (Mealy), then go to DECODE.
  - Otherwise stay, with ir_we=pc_we=0.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target precompute). Latch opcode_funct into an internal register; all later states use the latched value. Next state:
  - 7'h23 lw or 7'h2b sw -> MEMADR
  - 7'h60/62/64/65/66/67 (add/sub/and/or/xor/nor) or 7'h08/0c/0d/0e (addi/andi/ori/xori) -> EXEC
  - 7'h04 beq or 7'h05 bne -> BRANCH
  - 7'h02 j or 7'h48 jr -> JUMP
  - anything else -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1. On mem_ready go to MEMWB.
- MEMWB: rf_we=1, mem_to_reg=1, reg_dst=0, retire=1.
- MEMWR: mem_req=1, mem_we=1. On mem_ready: retire=1 and the instruction ends.
- EXEC: alu_src_a=1; alu_src_b=00 for R-type, 10 for immediates. Next: ALUWB.
- ALUWB: rf_we=1, reg_dst=latched bit6, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_src=01, retire=1. pc_we=zero for beq, pc_we=~zero for bne.
- JUMP: pc_we=1, retire=1; pc_src=10 for j, 11 for jr.
- Instruction end (any retire cycle): next state is FETCH if run=1, IDLE if run=0. A run drop mid-instruction never aborts the instruction.
- Timeout: a 16-bit counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle mem_req=1 and mem_ready=0. When it reaches TIMEOUT_CYCLES with mem_ready still 0, go to TRAP.
  - mem_ready arriving in that same cycle counts as success.
- TRAP: all outputs 0 except illegal=1. Exited only by rst.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Every non-memory instruction ends in bounded time. Latency from DECODE: R/I ALU = 4 cycles incl. FETCH, branch/jump = 3 cycles, lw = 5 + memory waits.

Optional Feature:
MC_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle state != IDLE and != TRAP.
  - instr_cnt increments on every retire.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then run=1, opcode_funct=7'h60, mem_ready=1 always -> states 1,2,7,8,1; rf_we=1 and reg_dst=1 only in ALUWB; retire pulses once per 4 cycles.
- lw (7'h23) with mem_ready delayed 3 cycles in both FETCH and MEMRD -> mem_req held high throughout each wait; MEMWB shows rf_we=1, mem_to_reg=1; retire 1 cycle.
- beq (7'h04) with zero=1, then zero=0 -> pc_we=1 with pc_src=01 in the first BRANCH, pc_we=0 in the second; bne (7'h05) with zero=0 -> pc_we=1.
- opcode_funct=7'h3f in DECODE -> state=11, illegal=1, all enables 0; outputs held until rst=1 returns state=0, illegal=0.
- TIMEOUT_CYCLES=4 with mem_ready=0 in FETCH -> TRAP entered exactly 4 cycles after entering FETCH; a repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap.
- run dropped during EXEC of addi (7'h08) -> ALUWB completes with retire=1, then IDLE; run=1 resumes FETCH next cycle; rst asserted mid-MEMWR with mem_ready=1 -> IDLE, no retire.
